// File: rtl/mw_add_seq.sv
// Multi-word sequential adder: one 16-bit CLA slice reused per clock, LSB first.
// Optional subtract support (op port) enabled by defining MW_ADD_SUB_EN.
module mw_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate for each 4-bit block
  for (genvar j = 0; j < 4; j++) begin : g_grp
    assign gg[j] = g[4*j+3]
                 | (p[4*j+3] & g[4*j+2])
                 | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                 | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    assign gp[j] = &p[4*j +: 4];

    assign c[4*j]   = gc[j];
    assign c[4*j+1] = g[4*j]
                    | (p[4*j] & gc[j]);
    assign c[4*j+2] = g[4*j+1]
                    | (p[4*j+1] & g[4*j])
                    | (p[4*j+1] & p[4*j] & gc[j]);
    assign c[4*j+3] = g[4*j+2]
                    | (p[4*j+2] & g[4*j+1])
                    | (p[4*j+2] & p[4*j+1] & g[4*j])
                    | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
  end

  // Second-level lookahead across the four groups
  assign gc[0] = ci;
  assign gc[1] = gg[0] | (gp[0] & ci);
  assign gc[2] = gg[1]
               | (gp[1] & gg[0])
               | (gp[1] & gp[0] & ci);
  assign gc[3] = gg[2]
               | (gp[2] & gg[1])
               | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & ci);
  assign gc[4] = gg[3]
               | (gp[3] & gg[2])
               | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & ci);

  assign s  = p ^ c;
  assign co = gc[4];
endmodule

module mw_add_seq #(
  parameter int WORDS = 4,
  localparam int W  = 16 * WORDS,
  localparam int KW = $clog2(WORDS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef MW_ADD_SUB_EN
  input  logic         op,
`endif
  output logic         result_valid,
  input  logic         result_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [15:0]   a_s;
  logic [15:0]   b_s;
  logic [15:0]   s_s;
  logic          co_s;
  logic          last;

  always_comb begin
    a_s = a_q[15:0];
    b_s = b_q[15:0];
    for (int i = 0; i < WORDS; i++) begin
      if (k_q == KW'(i)) begin
        a_s = a_q[16*i +: 16];
        b_s = b_q[16*i +: 16];
      end
    end
  end

  mw_cla16 u_cla (
    .a  (a_s),
    .b  (b_s),
    .ci (carry_q),
    .s  (s_s),
    .co (co_s)
  );

  assign last = (k_q == KW'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start_valid) begin
          a_d = a;
`ifdef MW_ADD_SUB_EN
          // Subtract as A + ~B + 1; cout then reads as no-borrow
          b_d     = op ? ~b : b;
          carry_d = op ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          k_d     = '0;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        for (int i = 0; i < WORDS; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[16*i +: 16] = s_s;
          end
        end
        carry_d = co_s;
        k_d     = k_q + KW'(1);
        if (last) begin
          cout_d  = co_s;
          ovf_d   = (a_q[W-1] == b_q[W-1])
                 && (s_s[15] != a_q[W-1]);
          k_d     = '0;
          state_d = DONE;
        end
      end
      (state_q == DONE): begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign sum          = sum_q;
  assign cout         = cout_q;
  assign ovf          = ovf_q;
endmodule

// File: tb/tb_mw_add_seq.sv
// Bench for mw_add_seq (WORDS=4): arithmetic model plus directed vectors.
// Subtract vector runs only when MW_ADD_SUB_EN is defined.
module tb_mw_add_seq;
  localparam int WORDS = 4;
  localparam int W = 16 * WORDS;
`ifdef MW_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef logic [W:0] v_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  mw_add_seq #(.WORDS(WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .cin          (cin),
`ifdef MW_ADD_SUB_EN
    .op           (op),
`endif
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .cout         (cout),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input v_t act, input v_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 busy, 2 result held
  int           m_phase = 0;
  int           m_cnt = 0;
  bit           m_on = 1'b0;
  logic [W-1:0] m_sum, p_sum;
  logic         m_cout, p_cout;
  logic         m_ovf, p_ovf;

  always @(posedge clk) begin
    logic [W:0]   t;
    logic [W-1:0] be;
    logic         ci;
    if (rst) begin
      m_on    <= 1'b1;
      m_phase <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_phase == 0) begin
      if (start_valid) begin
        be = (SUB_EN && op) ? ~b : b;
        ci = (SUB_EN && op) ? 1'b1 : cin;
        t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
        p_sum   <= t[W-1:0];
        p_cout  <= t[W];
        p_ovf   <= (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
        m_cnt   <= WORDS;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_phase <= 2;
        m_sum   <= p_sum;
        m_cout  <= p_cout;
        m_ovf   <= p_ovf;
      end
    end else if (result_ready) begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("start_ready", v_t'(start_ready), v_t'(m_phase == 0));
      chk("result_valid", v_t'(result_valid), v_t'(m_phase == 2));
      if (m_phase != 1) begin
        chk("sum", v_t'(sum), v_t'(m_sum));
        chk("cout", v_t'(cout), v_t'(m_cout));
        chk("ovf", v_t'(ovf), v_t'(m_ovf));
      end
    end
  end

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start_valid = 1'b0;
    end
    chk("valid_timeout", v_t'(result_valid), v_t'(1));
  endtask

  task automatic do_op(input string nm,
                       input logic [W-1:0] ia, ib,
                       input logic ic, io,
                       input logic [W-1:0] es,
                       input logic ec, eo);
    int lat;
    @(negedge clk);
    a = ia; b = ib; cin = ic; op = io;
    start_valid = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    wait_valid(lat);
    chk({nm, "_lat"}, v_t'(lat - 1), v_t'(WORDS));
    chk({nm, "_sum"}, v_t'(sum), v_t'(es));
    chk({nm, "_cout"}, v_t'(cout), v_t'(ec));
    chk({nm, "_ovf"}, v_t'(ovf), v_t'(eo));
    chk({nm, "_model"}, v_t'({m_cout, m_sum}), v_t'({ec, es}));
    @(posedge clk);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    start_valid = 1'b0;
    result_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", v_t'(start_ready), v_t'(1));
    chk("rst_valid", v_t'(result_valid), v_t'(0));
    chk("rst_sum", v_t'({cout, ovf, sum}), v_t'(0));

    do_op("carry16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 1'b0);
    do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
          64'h0, 1'b1, 1'b0);
    do_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Backpressure with a second request held pending
    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'h1111_1111_1111_1111;
    cin = 1'b1;
    start_valid = 1'b1;
    result_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 64'h8000_0000_0000_0000;
    b = 64'h8000_0000_0000_0000;
    cin = 1'b0;
    lat = 1;
    while (!result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_timeout", v_t'(result_valid), v_t'(1));
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", v_t'(start_ready), v_t'(0));
      chk("bp_valid", v_t'(result_valid), v_t'(1));
      chk("bp_sum", v_t'({cout, ovf, sum}),
          v_t'({2'b00, 64'h2345_6789_ABCD_F002}));
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle", v_t'(start_ready), v_t'(1));
    @(posedge clk);
    wait_valid(lat);
    chk("bp2_lat", v_t'(lat - 1), v_t'(WORDS));
    chk("bp2_sum", v_t'(sum), v_t'(0));
    chk("bp2_flags", v_t'({cout, ovf}), v_t'(2'b11));
    @(posedge clk);

    // Reset pulse while slice 2 is next
    @(negedge clk);
    a = '1; b = '1; cin = 1'b1;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready", v_t'(start_ready), v_t'(1));
    chk("mid_valid", v_t'(result_valid), v_t'(0));
    chk("mid_out", v_t'({cout, sum}), v_t'(0));
    do_op("after_rst", 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000,
          1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b1, 1'b0);

    if (SUB_EN) begin
      do_op("sub", 64'h5, 64'h7, 1'b0, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    end

    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
